dram_bram_responder: RTL and testbench

Single-clock, BRAM-backed responder for the DRAM controller side (dram_*) of the 144-bit two-beat DRAM command interface. It sits where the DDR2 controller normally sits, below the async DRAM bridge. It accepts read/write commands, stores write bursts with byte enables, and returns read bursts at a fixed latency. It is used for simulation and bring-up without physical DRAM, and models calibration delay and ready backpressure.

---
 rtl/dram_bram_responder.sv | 161 ++++++++++++++++
 tb/tb_dram_bram_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_bram_responder.sv
// BRAM-backed stand-in for the DRAM controller: two-beat 144-bit bursts, byte-enable writes, fixed-latency reads.
// Optional DRAM_RESP_STALL_EN adds LFSR-driven dram_ready stalls after calibration.
module dram_bram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 64
) (
  input  logic         dram_clk,
  input  logic         dram_reset_n,
  input  logic [31:0]  dram_address,
  input  logic         dram_rnw,
  input  logic         dram_cmd_en,
  output logic         dram_ready,
  input  logic [143:0] dram_data_o,
  input  logic [17:0]  dram_byte_enable,
  output logic [143:0] dram_data_i,
  output logic         dram_data_valid,
  output logic         init_done,
  output logic         err_cmd
);

  localparam int DEPTH = 2 ** (ADDR_BITS + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY} state_t;

  state_t                 r_state;
  logic [15:0]            r_init_cnt;
  logic                   r_ready;
  logic                   r_init_done;
  logic                   r_err;
  logic                   r_wr_beat1;
  logic                   r_rd_beat1;
  logic [ADDR_BITS-1:0]   r_cmd_addr;
  logic                   r_dv;
  logic [143:0]           r_dat_out;
  logic [143:0]           r_mem [0:DEPTH-1];
  logic                   r_rd_vld [1:RD_LATENCY-1];
  logic [143:0]           r_rd_dat [1:RD_LATENCY-1];

  logic                   w_accept;
  logic                   w_wr_en;
  logic [ADDR_BITS:0]     w_wr_idx;
  logic                   w_rd_en;
  logic [ADDR_BITS:0]     w_rd_idx;
  logic                   w_free;
  logic                   w_unused_addr;

  assign w_unused_addr = ^dram_address[31:ADDR_BITS];

  assign w_accept = dram_cmd_en & r_ready;
  assign w_wr_en  = (w_accept & ~dram_rnw) | r_wr_beat1;
  assign w_wr_idx = r_wr_beat1 ? {r_cmd_addr, 1'b1} : {dram_address[ADDR_BITS-1:0], 1'b0};
  assign w_rd_en  = (w_accept & dram_rnw) | r_rd_beat1;
  assign w_rd_idx = r_rd_beat1 ? {r_cmd_addr, 1'b1} : {dram_address[ADDR_BITS-1:0], 1'b0};

`ifdef DRAM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_step;
  logic [15:0] w_lfsr_upcoming;

  // Fibonacci form of x^16+x^14+x^13+x^11+1
  assign w_lfsr_step     = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_lfsr_upcoming = r_init_done ? w_lfsr_step : r_lfsr;
  assign w_free          = |w_lfsr_upcoming[1:0];

  always_ff @(posedge dram_clk or negedge dram_reset_n) begin
    if (!dram_reset_n) begin
      r_lfsr <= 16'hACE1;
    end else if (r_init_done) begin
      r_lfsr <= w_lfsr_step;
    end
  end
`else
  assign w_free = 1'b1;
`endif

  // dram_ready is registered, so each transition decides the value for the following cycle.
  always_ff @(posedge dram_clk or negedge dram_reset_n) begin
    if (!dram_reset_n) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= 16'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_wr_beat1  <= 1'b0;
      r_rd_beat1  <= 1'b0;
      r_cmd_addr  <= '0;
    end else begin
      r_err      <= r_err | (dram_cmd_en & ~r_ready);
      r_wr_beat1 <= w_accept & ~dram_rnw;
      r_rd_beat1 <= w_accept & dram_rnw;
      if (w_accept) begin
        r_cmd_addr <= dram_address[ADDR_BITS-1:0];
      end
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == 16'(INIT_CYCLES - 1)) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
            r_ready     <= w_free;
          end else begin
            r_init_cnt <= r_init_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_ready <= 1'b0;
          end else begin
            r_ready <= w_free;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= w_free;
        end
      endcase
    end
  end

  // Both read beats are sampled before any later write can land, then delayed as data.
  always_ff @(posedge dram_clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 18; k++) begin
        if (dram_byte_enable[k]) begin
          r_mem[w_wr_idx][8*k +: 8] <= dram_data_o[8*k +: 8];
        end
      end
    end
    r_rd_dat[1] <= r_mem[w_rd_idx];
    for (int s = 2; s < RD_LATENCY; s++) begin
      r_rd_dat[s] <= r_rd_dat[s-1];
    end
  end

  always_ff @(posedge dram_clk or negedge dram_reset_n) begin
    if (!dram_reset_n) begin
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_rd_vld[s] <= 1'b0;
      end
      r_dv      <= 1'b0;
      r_dat_out <= '0;
    end else begin
      r_rd_vld[1] <= w_rd_en;
      for (int s = 2; s < RD_LATENCY; s++) begin
        r_rd_vld[s] <= r_rd_vld[s-1];
      end
      r_dv <= r_rd_vld[RD_LATENCY-1];
      if (r_rd_vld[RD_LATENCY-1]) begin
        r_dat_out <= r_rd_dat[RD_LATENCY-1];
      end
    end
  end

  assign dram_ready      = r_ready;
  assign init_done       = r_init_done;
  assign err_cmd         = r_err;
  assign dram_data_valid = r_dv;
  assign dram_data_i     = r_dat_out;

endmodule

// File: tb/tb_dram_bram_responder.sv
// Randomized scoreboard bench for dram_bram_responder against a burst-level memory model.
module tb_dram_bram_responder;

  localparam int AB   = 10;
  localparam int RL   = 4;
  localparam int INIT = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  addr = '0;
  logic         rnw = 1'b0;
  logic         cmd_en = 1'b0;
  logic         ready;
  logic [143:0] wdat = '0;
  logic [17:0]  be = '0;
  logic [143:0] rdat;
  logic         dv;
  logic         idone;
  logic         err;

  dram_bram_responder #(.ADDR_BITS(AB), .RD_LATENCY(RL), .INIT_CYCLES(INIT)) dut (
    .dram_clk(clk), .dram_reset_n(rst_n), .dram_address(addr), .dram_rnw(rnw),
    .dram_cmd_en(cmd_en), .dram_ready(ready), .dram_data_o(wdat),
    .dram_byte_enable(be), .dram_data_i(rdat), .dram_data_valid(dv),
    .init_done(idone), .err_cmd(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [143:0] dat; } exp_t;
  exp_t         sb[$];
  logic [143:0] mem_m [0:2**(AB+1)-1];
  int           cyc = 0;
  int           pass_cnt = 0;
  int           tot_cnt = 0;
  logic [143:0] last_dat = '0;

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%h want=%h at cyc %0d", nm, act, exp, cyc);
  endtask

  // Monitor: every read beat must match the head of the scoreboard in data and cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_dat = '0;
      if (dv) chk("valid_in_reset", 144'(dv), 144'd0);
    end else if (dv) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 144'(dv), 144'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_cycle", 144'(cyc), 144'(e.cyc));
        chk("rd_data", rdat, e.dat);
      end
      last_dat = rdat;
    end else begin
      chk("data_hold", rdat, last_dat);
    end
  end

  function automatic logic [143:0] rand144();
    return {16'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_write(input logic [AB:0] idx, input logic [143:0] d, input logic [17:0] b);
    for (int k = 0; k < 18; k++)
      if (b[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 144'(ready), 144'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [143:0] d0, input logic [143:0] d1,
                          input logic [17:0] b0, input logic [17:0] b1);
    wait_ready();
    addr = a; rnw = 1'b0; cmd_en = 1'b1; wdat = d0; be = b0;
    model_write({a[AB-1:0], 1'b0}, d0, b0);
    model_write({a[AB-1:0], 1'b1}, d1, b1);
    @(posedge clk); #1;
    cmd_en = 1'b0; wdat = d1; be = b1;
    @(posedge clk); #1;
    wdat = '0; be = '0;
  endtask

  task automatic do_read(input logic [31:0] a);
    exp_t e;
    wait_ready();
    addr = a; rnw = 1'b1; cmd_en = 1'b1;
    e.cyc = cyc + RL;     e.dat = mem_m[{a[AB-1:0], 1'b0}]; sb.push_back(e);
    e.cyc = cyc + RL + 1; e.dat = mem_m[{a[AB-1:0], 1'b1}]; sb.push_back(e);
    @(posedge clk); #1;
    cmd_en = 1'b0;
  endtask

  task automatic check_init();
    repeat (INIT - 1) @(posedge clk);
    @(negedge clk);
    chk("ready_before_init", 144'(ready), 144'd0);
    chk("init_done_before", 144'(idone), 144'd0);
    @(negedge clk);
    chk("ready_at_init", 144'(ready), 144'd1);
    chk("init_done_at_init", 144'(idone), 144'd1);
    chk("err_after_init", 144'(err), 144'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [143:0] ones;
    int acc_cnt;
    logic acc, prev_acc, seen_rej;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 144'(ready), 144'd0);
    chk("rst_valid", 144'(dv), 144'd0);
    chk("rst_data", rdat, 144'd0);
    chk("rst_init_done", 144'(idone), 144'd0);
    chk("rst_err", 144'(err), 144'd0);
    rst_n = 1'b1;
    check_init();

    for (int a = 0; a < 16; a++) do_write(32'(a), rand144(), rand144(), '1, '1);

    do_write(32'h5, {9{16'hAAAA}}, {9{16'h5555}}, '1, '1);
    do_read(32'h5);

    do_write(32'h7, ones, ones, '1, '1);
    do_write(32'h7, '0, '0, 18'h00001, 18'h00000);
    do_read(32'h7);

    do_write(32'h9, rand144(), rand144(), '1, '1);
    do_read(32'h9);

    do_read(32'h403);
    do_write(32'h3, rand144(), rand144(), '1, '1);
    do_read(32'h3);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = {22'($urandom), 10'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 1) do_read(ra);
      else do_write(ra, rand144(), rand144(), 18'($urandom), 18'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    chk("err_before_protocol", 144'(err), 144'd0);
    acc_cnt = 0; prev_acc = 1'b0; seen_rej = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      logic [31:0] ra;
      chk("err_sticky", 144'(err), 144'(seen_rej));
      ra = 32'($urandom_range(0, 15));
      addr = ra; rnw = 1'b1; cmd_en = 1'b1;
      acc = ready;
      if (acc) begin
        acc_cnt++;
        e.cyc = cyc + RL;     e.dat = mem_m[{ra[AB-1:0], 1'b0}]; sb.push_back(e);
        e.cyc = cyc + RL + 1; e.dat = mem_m[{ra[AB-1:0], 1'b1}]; sb.push_back(e);
      end else begin
        seen_rej = 1'b1;
      end
      chk("no_back_to_back", 144'(acc & prev_acc), 144'd0);
      prev_acc = acc;
      @(posedge clk); #1;
    end
    cmd_en = 1'b0;
`ifndef DRAM_RESP_STALL_EN
    chk("protocol_accepts", 144'(acc_cnt), 144'd5);
`endif
    repeat (3) begin @(posedge clk); #1; end
    chk("err_stays", 144'(err), 144'd1);

    repeat (RL + 4) begin @(posedge clk); #1; end
    do_read(32'h5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_valid", 144'(dv), 144'd0);
    chk("midrst_init_done", 144'(idone), 144'd0);
    chk("midrst_err", 144'(err), 144'd0);
    rst_n = 1'b1;
    check_init();
    do_read(32'h5);
    do_read(32'h7);
    do_read(32'h3);
    for (int a = 0; a < 16; a++) do_read(32'(a));

    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 144'(sb.size()), 144'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
